// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package loader_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI = 3'd0,
    S_LEN_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CSUM   = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_t;

  localparam int unsigned HDR_BYTES      = 2;
  localparam int unsigned BYTES_PER_WORD = 4;

endpackage

// File: rtl/word_packer.sv
// Packs accepted bytes MSB-first into 32-bit words.
// Latency: word/word_full are combinational on the byte that completes a word.
// Backpressure: none; only advances when en is high, so partial words persist.
//
// Ports:
//   clk, rst    clock and synchronous active-high clear
//   en, din     accept one data byte this cycle
//   word        packed word (earlier bytes plus din), valid while word_full
//   word_full   high in the cycle the final byte of a word is accepted
module word_packer
  import loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [23:0] shreg;
  logic [1:0]  idx;

  // Word is presented combinationally so the loader can register the write
  // on the same edge that accepts the last byte.
  assign word      = {shreg, din};
  assign word_full = en && (idx == 2'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
    end else if (en) begin
      shreg <= {shreg[15:0], din};
      idx   <= idx + 2'd1;   // wraps 3 -> 0 at the word boundary
    end
  end

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory.
// Latency: imem write one cycle after a word's 4th byte; done one cycle after checksum.
// Backpressure: in_ready decoded from state; drops to 0 only in DONE/ERR.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   in_valid, in_data, in_ready    byte stream handshake
//   imem_we, imem_addr, imem_wdata instruction-memory write port (registered)
//   core_rst                       holds the core in reset until load succeeds
//   done, error                    terminal status flags
module program_loader
  import loader_pkg::*;
#(
  parameter int unsigned MAX_WORDS = 256,
  parameter int unsigned CNT_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        error
);

  state_t           state;
  logic [7:0]       len_hi;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] wcnt;
  logic [7:0]       csum;

  logic        xfer;
  logic        data_en;
  logic [15:0] hdr_len;
  logic [31:0] word;
  logic        word_full;

  assign in_ready = (state != S_DONE) && (state != S_ERR);
  assign xfer     = in_valid && in_ready;
  assign data_en  = xfer && (state == S_DATA);
  assign hdr_len  = {len_hi, in_data};

  word_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .en        (data_en),
    .din       (in_data),
    .word      (word),
    .word_full (word_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_LEN_HI;
      len_hi     <= '0;
      len        <= '0;
      wcnt       <= '0;
      csum       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      imem_we <= 1'b0;
      case (state)
        S_LEN_HI: begin
          if (xfer) begin
            len_hi <= in_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (xfer) begin
            len <= CNT_W'(hdr_len);
            // Range check happens here so the word counter can never wrap.
            if ({16'd0, hdr_len} > MAX_WORDS) begin
              state <= S_ERR;
              error <= 1'b1;
            end else if (hdr_len == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (xfer) begin
            csum <= csum ^ in_data;
            if (word_full) begin
              imem_we    <= 1'b1;
              imem_addr  <= 32'({wcnt, 2'b00});
              imem_wdata <= word;
              wcnt       <= wcnt + CNT_W'(1);
              if (wcnt + CNT_W'(1) == len) state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (xfer) begin
            if (in_data == csum) begin
              state    <= S_DONE;
              done     <= 1'b1;
              core_rst <= 1'b0;
            end else begin
              state <= S_ERR;
              error <= 1'b1;
            end
          end
        end
        default: ;  // S_DONE / S_ERR hold until reset
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed image cases plus random
// streams, all compared every cycle against a byte-queue reference model.
module tb_program_loader;

  localparam int MAXW = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        core_rst;
  logic        done;
  logic        error;

  int tests = 0;
  int fails = 0;

  program_loader #(.MAX_WORDS(MAXW), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // The model only remembers which bytes were accepted since reset; every
  // expected output is derived from that list by the stream-format rules.
  logic [7:0] acc[$];
  int         last_k  = -1;
  bit         started = 0;

  function automatic int hdr_n();
    return int'({acc[0], acc[1]});
  endfunction

  // 0 = still loading, 1 = done, 2 = error
  function automatic int mstatus();
    int n;
    logic [7:0] x;
    if (acc.size() < 2) return 0;
    n = hdr_n();
    if (n > MAXW) return 2;
    if (acc.size() < 2 + 4 * n + 1) return 0;
    x = 8'h00;
    for (int i = 2; i < 2 + 4 * n; i++) x = x ^ acc[i];
    return (x == acc[2 + 4 * n]) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      acc.delete();
      last_k  = -1;
      started = 1;
    end else begin
      last_k = -1;
      if (in_valid && mstatus() == 0) begin
        acc.push_back(in_data);
        last_k = acc.size() - 1;
      end
    end
  end

  // writes seen from the DUT, used by the directed literal checks
  logic [31:0] cap_addr[$];
  logic [31:0] cap_data[$];

  always @(negedge clk) begin
    int  st;
    bit  exp_we;
    int  n;
    if (started) begin
      st     = mstatus();
      exp_we = 0;
      if (last_k >= 2) begin
        n = hdr_n();
        if (n <= MAXW && last_k < 2 + 4 * n && ((last_k - 2) % 4) == 3) exp_we = 1;
      end
      chk("in_ready", 32'(in_ready), 32'(st == 0));
      chk("core_rst", 32'(core_rst), 32'(st != 1));
      chk("done",     32'(done),     32'(st == 1));
      chk("error",    32'(error),    32'(st == 2));
      chk("imem_we",  32'(imem_we),  32'(exp_we));
      if (exp_we) begin
        chk("imem_addr",  imem_addr, 32'(((last_k - 2) / 4) * 4));
        chk("imem_wdata", imem_wdata,
            {acc[last_k - 3], acc[last_k - 2], acc[last_k - 1], acc[last_k]});
      end
      if (imem_we === 1'b1) begin
        cap_addr.push_back(imem_addr);
        cap_data.push_back(imem_wdata);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    cap_addr.delete();
    cap_data.delete();
  endtask

  // gap: 0 = back-to-back, 1 = idle cycle before every byte, 2 = random idles.
  // A byte is offered for one cycle; outside DONE/ERR in_ready is always high.
  task automatic send(input logic [7:0] s[$], input int gap);
    for (int i = 0; i < s.size(); i++) begin
      if (gap == 1 || (gap == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
      end
      in_valid = 1'b1;
      in_data  = s[i];
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    logic [7:0] x;
    int n;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    tick();
    do_reset();
    @(negedge clk);
    chk("rst in_ready",   32'(in_ready),   32'd1);
    chk("rst imem_we",    32'(imem_we),    32'd0);
    chk("rst imem_addr",  imem_addr,       32'd0);
    chk("rst imem_wdata", imem_wdata,      32'd0);
    chk("rst core_rst",   32'(core_rst),   32'd1);
    chk("rst done",       32'(done),       32'd0);
    chk("rst error",      32'(error),      32'd0);
    #2;

    // two-word image; AC is the XOR of the eight data bytes
    do_reset();
    s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04, 8'hAC};
    send(s, 0);
    @(negedge clk);
    chk("img2 done",     32'(done),     32'd1);
    chk("img2 core_rst", 32'(core_rst), 32'd0);
    chk("img2 nwrites",  32'(cap_addr.size()), 32'd2);
    if (cap_addr.size() == 2) begin
      chk("img2 addr0", cap_addr[0], 32'h0);
      chk("img2 data0", cap_data[0], 32'h20080005);
      chk("img2 addr1", cap_addr[1], 32'h4);
      chk("img2 data1", cap_data[1], 32'h8C090004);
    end
    #2;

    // same image with a bad checksum, then extra bytes must be ignored
    do_reset();
    s[10] = 8'h80;
    send(s, 0);
    @(negedge clk);
    chk("badcs error",    32'(error),    32'd1);
    chk("badcs core_rst", 32'(core_rst), 32'd1);
    chk("badcs in_ready", 32'(in_ready), 32'd0);
    #2;
    cap_addr.delete();
    s = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(s, 0);
    tick();
    chk("badcs nowrites", 32'(cap_addr.size()), 32'd0);

    // oversize header 257
    do_reset();
    s = '{8'h01, 8'h01};
    send(s, 0);
    @(negedge clk);
    chk("ovf error", 32'(error), 32'd1);
    #2;
    s = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    send(s, 0);
    tick();
    chk("ovf nowrites", 32'(cap_addr.size()), 32'd0);

    // empty image
    do_reset();
    s = '{8'h00, 8'h00, 8'h00};
    send(s, 0);
    @(negedge clk);
    chk("empty done",     32'(done), 32'd1);
    chk("empty nowrites", 32'(cap_addr.size()), 32'd0);
    #2;

    // one word, valid toggling every other cycle
    do_reset();
    s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22};
    send(s, 1);
    @(negedge clk);
    chk("toggle done",    32'(done), 32'd1);
    chk("toggle nwrites", 32'(cap_addr.size()), 32'd1);
    if (cap_data.size() == 1) chk("toggle data", cap_data[0], 32'hDEADBEEF);
    #2;

    // reset after five data bytes of a two-word load, then a fresh image
    do_reset();
    s = '{8'h00, 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    send(s, 0);
    do_reset();
    s = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send(s, 0);
    @(negedge clk);
    chk("rstmid done",    32'(done), 32'd1);
    chk("rstmid nwrites", 32'(cap_addr.size()), 32'd1);
    if (cap_addr.size() == 1) begin
      chk("rstmid addr", cap_addr[0], 32'h0);
      chk("rstmid data", cap_data[0], 32'h12345678);
    end
    #2;

    // random images checked by the per-cycle model
    for (int t = 0; t < 60; t++) begin
      do_reset();
      s.delete();
      n = ($urandom_range(0, 9) == 0) ? $urandom_range(MAXW + 1, 400) : $urandom_range(0, 6);
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      x = 8'h00;
      if (n <= MAXW) begin
        for (int i = 0; i < 4 * n; i++) begin
          s.push_back(8'($urandom));
          x = x ^ s[s.size() - 1];
        end
        s.push_back(($urandom_range(0, 3) == 0) ? (x ^ 8'(1 << $urandom_range(0, 7))) : x);
      end
      if ($urandom_range(0, 7) == 0 && s.size() > 3) begin
        while (s.size() > 3 && $urandom_range(0, 3) != 0) void'(s.pop_back());
        send(s, 2);
        rst = 1'b1;  // reset coinciding with an offered byte
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        s = '{8'h00, 8'h00, 8'h00};
      end
      s.push_back(8'($urandom));
      s.push_back(8'($urandom));
      send(s, 2);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
